// File: rtl/apu_pkg.sv
// Shared constants and types for the UART-to-APU register writer.
// Byte-format field positions and the receiver state encoding live here.
`timescale 1ns/1ps
package apu_pkg;

  localparam int APU_REG_COUNT = 16;
  localparam int ADDR_W        = $clog2(APU_REG_COUNT);

  // Address byte layout: 1 00 iiii d  (mark, kind, register index, data bit 7)
  localparam int ADDR_MARK_BIT = 7;
  localparam int ADDR_KIND_MSB = 6;
  localparam int ADDR_KIND_LSB = 5;
  localparam int ADDR_IDX_MSB  = 4;
  localparam int ADDR_IDX_LSB  = 1;
  localparam int ADDR_D7_BIT   = 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling timer and RX FSM.
// byte_valid and frame_err are single-cycle combinational strobes from the STOP state.
`timescale 1ns/1ps
module uart_rx
  import apu_pkg::*;
#(
  parameter int CLK_HZ = 1789773,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BIT_CYCLES = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2);

  logic            sync1_reg;
  logic            rxs_reg;
  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rxs_reg   <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // A load of N makes the sample point land exactly N cycles later.
  assign expire = (cnt_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - CW'(1) : cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxs_reg) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (expire) begin
          if (rxs_reg) begin
            state_next = IDLE;
          end else begin
            cnt_next   = FULL_LOAD;
            bit_next   = 3'd0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_next = {rxs_reg, shift_reg[7:1]};
          cnt_next   = FULL_LOAD;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          if (rxs_reg) begin
            byte_valid = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_data = shift_reg;

endmodule

// File: rtl/uart_apu_reg_writer.sv
// Pairs a data byte (MSB 0) with a following address byte (MSB 1, kind 00)
// received over UART into one write strobe for the 16 APU registers.
`timescale 1ns/1ps
module uart_apu_reg_writer
  import apu_pkg::*;
#(
  parameter int CLK_HZ = 1789773,
  parameter int BAUD   = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic              frame_err,
  output logic              seq_err
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       rx_frame_err;
  logic       pend_reg;
  logic [6:0] pend_data_reg;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (rx_frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we        <= 1'b0;
      reg_addr      <= '0;
      reg_data      <= '0;
      frame_err     <= 1'b0;
      seq_err       <= 1'b0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
    end else begin
      reg_we    <= 1'b0;
      seq_err   <= 1'b0;
      frame_err <= rx_frame_err;
      if (rx_frame_err) begin
        pend_reg <= 1'b0;
      end else if (byte_valid) begin
        if (!byte_data[ADDR_MARK_BIT]) begin
          pend_data_reg <= byte_data[6:0];
          pend_reg      <= 1'b1;
        end else if (byte_data[ADDR_KIND_MSB:ADDR_KIND_LSB] == 2'b00) begin
          if (pend_reg) begin
            reg_we   <= 1'b1;
            reg_addr <= byte_data[ADDR_IDX_MSB:ADDR_IDX_LSB];
            reg_data <= {byte_data[ADDR_D7_BIT], pend_data_reg};
            pend_reg <= 1'b0;
          end else begin
            seq_err <= 1'b1;
          end
        end else begin
          // Unknown marked byte: drop it and forget any half-built write.
          pend_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apu_reg_writer.sv
// Self-checking bench: serial frames driven at 9600 baud, results compared
// against a byte-level model of the data/address pairing rules.
`timescale 1ns/1ps
module tb_uart_apu_reg_writer;

  localparam int BITC     = 186;   // round(1789773 / 9600)
  localparam int BREAK_CY = 8950;  // 5 ms at 1.789773 MHz

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;
  logic       frame_err;
  logic       seq_err;

  int tests  = 0;
  int failed = 0;

  logic [11:0] got_q[$];
  int          got_seq;
  int          got_frame;

  bit          m_pend;
  logic [7:0]  m_data;
  logic [11:0] exp_q[$];
  int          exp_seq;
  int          exp_frame;

  uart_apu_reg_writer dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .frame_err (frame_err),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we) got_q.push_back({reg_addr, reg_data});
    if (seq_err) got_seq++;
    if (frame_err) got_frame++;
    if (reg_we && (seq_err || frame_err)) begin
      failed++;
      $display("FAIL pulse_overlap: reg_we=%0b seq_err=%0b frame_err=%0b, required no overlap",
               reg_we, seq_err, frame_err);
    end
  end

  // Reference model: one call per correctly framed byte.
  task automatic model_byte(input logic [7:0] b);
    int v;
    v = b;
    if (v < 128) begin
      m_pend = 1'b1;
      m_data = 8'(v);
    end else if (v >= 160) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      exp_q.push_back({4'((v - 128) / 2), 8'((v % 2) * 128 + int'(m_data))});
      m_pend = 1'b0;
    end else begin
      exp_seq++;
    end
  endtask

  task automatic model_frame_error();
    exp_frame++;
    m_pend = 1'b0;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nstop);
    drive_bit(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BITC);
    drive_bit(stop_v, BITC * nstop);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1);
    model_byte(b);
    drive_bit(1'b1, 8);
  endtask

  task automatic new_case();
    got_q.delete();
    exp_q.delete();
    got_seq   = 0;
    got_frame = 0;
    exp_seq   = 0;
    exp_frame = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_pend = 1'b0;
    new_case();
    tests++;
    if ({reg_we, frame_err, seq_err} !== 3'b000) begin
      failed++;
      $display("FAIL reset_strobes: got %b required 000", {reg_we, frame_err, seq_err});
    end
    tests++;
    if ({reg_addr, reg_data} !== 12'h000) begin
      failed++;
      $display("FAIL reset_regs: got addr=%h data=%h required 0/00", reg_addr, reg_data);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_writes();
    logic [7:0] seq_bytes[8] = '{8'h27, 8'h83, 8'h02, 8'h81, 8'h7C, 8'h84, 8'h09, 8'h86};
    new_case();
    foreach (seq_bytes[i]) send_byte(seq_bytes[i]);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL writes_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL writes_value[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (got_seq != exp_seq || got_frame != exp_frame) begin
      failed++;
      $display("FAIL writes_errs: got seq=%0d frame=%0d required %0d/%0d", got_seq, got_frame, exp_seq, exp_frame);
    end
    tests++;
    if ({reg_addr, reg_data} !== 12'h309) begin
      failed++;
      $display("FAIL writes_hold: got %h required 309", {reg_addr, reg_data});
    end
    $display("[TB] test_writes: %0d writes seen", got_q.size());
  endtask

  task automatic test_seq_err();
    new_case();
    send_byte(8'h83);
    send_byte(8'h13);
    send_byte(8'h83);
    tests++;
    if (got_seq != exp_seq) begin
      failed++;
      $display("FAIL seq_err_count: got %0d required %0d", got_seq, exp_seq);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL seq_writes_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else if (got_q.size() > 0) begin
      tests++;
      if (got_q[0] !== exp_q[0]) begin
        failed++;
        $display("FAIL seq_write_value: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    $display("[TB] test_seq_err: seq_err pulses %0d", got_seq);
  endtask

  task automatic test_overwrite();
    new_case();
    send_byte(8'h1F);
    send_byte(8'h4B);
    send_byte(8'h83);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL overwrite_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else if (got_q.size() > 0) begin
      tests++;
      if (got_q[0] !== exp_q[0]) begin
        failed++;
        $display("FAIL overwrite_value: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    $display("[TB] test_overwrite: %0d writes", got_q.size());
  endtask

  task automatic test_frame_err();
    new_case();
    send_frame(8'h3A, 1'b0, 1);
    model_frame_error();
    drive_bit(1'b1, BITC);
    send_byte(8'h84);
    send_byte(8'h3A);
    send_byte(8'h84);
    tests++;
    if (got_frame != exp_frame) begin
      failed++;
      $display("FAIL frame_err_count: got %0d required %0d", got_frame, exp_frame);
    end
    tests++;
    if (got_q.size() != exp_q.size() || got_seq != exp_seq) begin
      failed++;
      $display("FAIL frame_writes: got %0d writes %0d seq, required %0d/%0d",
               got_q.size(), got_seq, exp_q.size(), exp_seq);
    end else if (got_q.size() > 0) begin
      tests++;
      if (got_q[0] !== exp_q[0]) begin
        failed++;
        $display("FAIL frame_write_value: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    $display("[TB] test_frame_err: frame_err pulses %0d", got_frame);
  endtask

  task automatic test_glitch_break();
    new_case();
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 2 * BITC);
    tests++;
    if (got_q.size() != 0 || got_seq != 0 || got_frame != 0) begin
      failed++;
      $display("FAIL glitch: got %0d writes %0d seq %0d frame, required none", got_q.size(), got_seq, got_frame);
    end
    drive_bit(1'b0, BREAK_CY);
    model_frame_error();
    drive_bit(1'b1, BITC);
    send_byte(8'h13);
    send_byte(8'h83);
    tests++;
    if (got_frame != exp_frame) begin
      failed++;
      $display("FAIL break_frame_count: got %0d required %0d", got_frame, exp_frame);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL break_recover_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else if (got_q.size() > 0) begin
      tests++;
      if (got_q[0] !== exp_q[0]) begin
        failed++;
        $display("FAIL break_recover_value: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    $display("[TB] test_glitch_break: frame_err pulses %0d", got_frame);
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    new_case();
    send_byte(8'h7C);
    b = 8'h84;
    drive_bit(1'b0, BITC);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BITC);
    drive_bit(b[4], 90);
    rst = 1'b1;
    m_pend = 1'b0;
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    drive_bit(1'b1, 2 * BITC);
    tests++;
    if (got_q.size() != 0 || got_seq != 0 || got_frame != 0) begin
      failed++;
      $display("FAIL abort_quiet: got %0d writes %0d seq %0d frame, required none", got_q.size(), got_seq, got_frame);
    end
    tests++;
    if ({reg_addr, reg_data} !== 12'h000) begin
      failed++;
      $display("FAIL abort_regs: got %h required 000", {reg_addr, reg_data});
    end
    send_byte(8'h7C);
    send_byte(8'h84);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL abort_recover_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else if (got_q.size() > 0) begin
      tests++;
      if (got_q[0] !== exp_q[0]) begin
        failed++;
        $display("FAIL abort_recover_value: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    $display("[TB] test_reset_abort: %0d writes after recovery", got_q.size());
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int kind;
    new_case();
    for (int n = 0; n < 10; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5) b = 8'($urandom_range(0, 127));
      else if (kind < 9) b = 8'($urandom_range(128, 159));
      else b = 8'($urandom_range(160, 255));
      send_frame(b, 1'b1, int'($urandom_range(1, 2)));
      model_byte(b);
    end
    drive_bit(1'b1, 8);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL b2b_value[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (got_seq != exp_seq || got_frame != exp_frame) begin
      failed++;
      $display("FAIL b2b_errs: got seq=%0d frame=%0d required %0d/%0d", got_seq, got_frame, exp_seq, exp_frame);
    end
    $display("[TB] test_back_to_back: %0d writes, %0d seq_err", got_q.size(), got_seq);
  endtask

  initial begin
    test_reset();
    test_writes();
    test_seq_err();
    test_overwrite();
    test_frame_err();
    test_glitch_break();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
